// File: rtl/pulse_train_gen_if.sv
// Start/busy/done bundle between control logic and pulse_train_gen.
// master: drives i_start/i_cnt; slave: drives o_pls/o_busy/o_done.
interface pulse_train_gen_if #(
  parameter int CNT_W = 4
);
  logic             i_start;
  logic [CNT_W-1:0] i_cnt;
  logic             o_pls;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start,
    output i_cnt,
    input  o_pls,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_start,
    input  i_cnt,
    output o_pls,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Emits i_cnt fixed-width pulses on o_pls, each followed by a gap.
// Ports: clk, rst (async, active high), bus (slave: start/cnt in, pls/busy/done out).
module pulse_train_gen #(
  parameter int CNT_W      = 4,
  parameter int PULSE_CLKS = 16,
  parameter int GAP_CLKS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  pulse_train_gen_if.slave  bus
);

  localparam int MAXC =
    (PULSE_CLKS > GAP_CLKS) ? PULSE_CLKS : GAP_CLKS;
  localparam int TW = $clog2(MAXC + 1);

  localparam logic [TW-1:0] T_HI = TW'(PULSE_CLKS - 1);
  localparam logic [TW-1:0] T_LO = TW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             pls_q, pls_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic tmr_zero;
  logic cnt_zero;

  assign tmr_zero = (tmr_q == '0);
  assign cnt_zero = (bus.i_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tmr_q   <= '0;
      pls_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      pls_q   <= pls_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are registered from the next state so they line up
  // with the state they describe, one cycle after the request.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          if (cnt_zero) begin
            done_d = 1'b1;
          end else begin
            rem_d   = bus.i_cnt;
            tmr_d   = T_HI;
            state_d = HIGH;
          end
        end
      end
      HIGH: begin
        if (tmr_zero) begin
          rem_d   = rem_q - CNT_W'(1);
          tmr_d   = T_LO;
          state_d = LOW;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      LOW: begin
        if (tmr_zero) begin
          if (rem_q != '0) begin
            tmr_d   = T_HI;
            state_d = HIGH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pls_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
  end

  assign bus.o_pls  = pls_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;

endmodule
